detector_secuencia_ctrl: RTL

- Test/stimulus controller for the serial "1011" sequence detector (Moore, 3-bit state, tick-qualified input, overlap allowed).
- Latches a parallel word, resets the detector, then serializes the word MSB-first into the detector's in/tick ports at a programmable tick rate.
- Counts detector matches and reports the count with busy/done status.
- Sits between a register/switch front end and one detector instance.

---
 rtl/detector_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/detector_secuencia_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/detector_pkg.sv
// Shared encodings for the "1011" detector and its stimulus controller.
package detector_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_TICK   = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        WAIT   = ST_WAIT,
        TICK   = ST_TICK,
        SAMPLE = ST_SAMPLE,
        FIN    = ST_FIN
    } ctrl_state_e;

    localparam logic [2:0] DET_S0 = 3'd0;
    localparam logic [2:0] DET_S1 = 3'd1;
    localparam logic [2:0] DET_S2 = 3'd2;
    localparam logic [2:0] DET_S3 = 3'd3;
    localparam logic [2:0] DET_S4 = 3'd4;

    localparam int DIV_MIN = 2;
    localparam int PRE_W   = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Loadable down-counter with a terminal-count flag for tick pacing.
module tick_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    assign tc_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/detector_secuencia_ctrl.sv
// Serializes a latched word into the "1011" detector and counts matches.
// Optional DETECTOR_CTRL_STOP_ON_MATCH_EN ends the run at the first match.
module detector_secuencia_ctrl
    import detector_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic [CNT_W-1:0] len,
    input  logic             det_out,
    output logic             det_reset,
    output logic             det_in,
    output logic             det_tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] match_pos
);

    localparam logic [PRE_W-1:0] LOAD_FIRST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] LOAD_NEXT  =
        (DIV > DIV_MIN) ? PRE_W'(DIV - 3) : '0;
    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             din_q, din_d;
    logic [CNT_W-1:0] len_clamped;
    logic             pre_load, pre_en, pre_tc;
    logic [PRE_W-1:0] pre_val;

`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] pos_q, pos_d;
`endif

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    tick_prescaler #(
        .W (PRE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (pre_load),
        .load_val_i (pre_val),
        .en_i       (pre_en),
        .tc_o       (pre_tc)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        match_d     = match_q;
        din_d       = din_q;
        pre_load    = 1'b0;
        pre_val     = LOAD_FIRST;
        pre_en      = 1'b0;
`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
        len_d       = len_q;
        pos_d       = pos_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d     = word;
                    bits_left_d = len_clamped;
                    match_d     = '0;
`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
                    len_d       = len_clamped;
                    pos_d       = '0;
`endif
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                pre_load = 1'b1;
                pre_val  = LOAD_FIRST;
                state_d  = (bits_left_q == '0) ? FIN : WAIT;
            end
            WAIT: begin
                pre_en = 1'b1;
                if (pre_tc) state_d = TICK;
            end
            TICK: begin
                din_d       = shreg_q[WIDTH-1];
                shreg_d     = shreg_q << 1;
                bits_left_d = bits_left_q - CNT_W'(1);
                state_d     = SAMPLE;
            end
            SAMPLE: begin
                // Detector moved on the TICK edge, so det_out is current.
                if (det_out && match_q != CNT_ONES) begin
                    match_d = match_q + CNT_W'(1);
                end
                if (bits_left_q == '0) begin
                    state_d = FIN;
                end else begin
                    pre_load = 1'b1;
                    pre_val  = LOAD_NEXT;
                    state_d  = (DIV > DIV_MIN) ? WAIT : TICK;
                end
`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
                if (det_out) begin
                    pos_d    = len_q - bits_left_q;
                    match_d  = CNT_W'(1);
                    pre_load = 1'b0;
                    state_d  = FIN;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            match_q     <= '0;
            din_q       <= 1'b0;
`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
            len_q       <= '0;
            pos_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            match_q     <= match_d;
            din_q       <= din_d;
`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
            len_q       <= len_d;
            pos_q       <= pos_d;
`endif
        end
    end

    assign det_reset   = (state_q == CLEAR);
    assign det_tick    = (state_q == TICK);
    assign det_in      = det_tick ? shreg_q[WIDTH-1] : din_q;
    assign busy        = (state_q == CLEAR) || (state_q == WAIT) ||
                         (state_q == TICK)  || (state_q == SAMPLE);
    assign done        = (state_q == FIN);
    assign match_count = match_q;

`ifdef DETECTOR_CTRL_STOP_ON_MATCH_EN
    assign match_pos = pos_q;
`else
    assign match_pos = '0;
`endif

endmodule
